alu_req_arbiter: RTL

Shares one registered 16-bit ALU (ops: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SHIFT, 5 SLT) between two requesters using round-robin arbitration. It accepts operand/op bundles over valid/ready handshakes, drives the ALU, waits out the ALU's registered latency, and returns the result to the requester that issued it. It sits between the control units that issue operations and the ALU instance.

---
 rtl/alu_req_arbiter_if.sv | 56 +++++
 rtl/alu_req_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter_if.sv
// Bundle of the two requester channels, the two response channels and the
// ALU drive/return signals handled by alu_req_arbiter.
// Handshake rule for every valid/ready pair: a transfer happens on the rising
// clock edge where valid and ready are both high; the data fields travelling
// with valid must be stable whenever valid is high.
interface alu_req_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic [2:0]  req1_op;
  logic        resp0_valid;
  logic        resp0_ready;
  logic [15:0] resp0_r;
  logic        resp0_lt;
  logic        resp0_err;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [15:0] resp1_r;
  logic        resp1_lt;
  logic        resp1_err;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_r;
  logic        alu_altb;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  resp0_ready, resp1_ready,
    input  alu_r, alu_altb,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_r, resp0_lt, resp0_err,
    output resp1_valid, resp1_r, resp1_lt, resp1_err,
    output alu_a, alu_b, alu_op
  );

  // Requesters plus ALU side
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output resp0_ready, resp1_ready,
    output alu_r, alu_altb,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_r, resp0_lt, resp0_err,
    input  resp1_valid, resp1_r, resp1_lt, resp1_err,
    input  alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one registered 16-bit ALU between two
// requesters. Accepts one operation at a time, drives the ALU for
// ALU_LATENCY+1 edges, captures the result and holds it on the response
// channel of the issuing requester until it is taken.
// Optional feature macro: ALU_ARB_STATS_EN adds saturating per-requester
// grant counters grant_cnt0 / grant_cnt1.
// Handshakes: transfer on the rising edge where valid and ready are both high.
module alu_req_arbiter #(
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W       = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_req_arbiter_if.slave    bus,
  output logic [1:0]          dbg_state
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]         grant_cnt0,
  output logic [15:0]         grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_IDLE = 3'd7;

  state_t             state;
  state_t             state_nxt;

  logic [15:0]        a_q;
  logic [15:0]        b_q;
  logic [2:0]         op_q;
  logic               id_q;
  logic               last_grant;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        r_q;
  logic               lt_q;
  logic               err_q;

  logic               gnt0;
  logic               gnt1;
  logic               acc;
  logic [15:0]        acc_a;
  logic [15:0]        acc_b;
  logic [2:0]         acc_op;
  logic               acc_ill;
  logic               cnt_done;
  logic               resp_hs;

  // Grant selection: a lone valid requester wins; on a tie the one that was
  // not served last wins. Re-evaluated every IDLE cycle, nothing is sticky.
  always_comb begin
    gnt0     = bus.req0_valid && (!bus.req1_valid || last_grant);
    gnt1     = bus.req1_valid && (!bus.req0_valid || !last_grant);
    acc      = (state == IDLE) && (gnt0 || gnt1);
    acc_a    = gnt1 ? bus.req1_a  : bus.req0_a;
    acc_b    = gnt1 ? bus.req1_b  : bus.req0_b;
    acc_op   = gnt1 ? bus.req1_op : bus.req0_op;
    acc_ill  = (acc_op[2:1] == 2'b11);
    cnt_done = (cnt == CNT_W'(ALU_LATENCY));
    resp_hs  = (state == RESP) && (id_q ? bus.resp1_ready : bus.resp0_ready);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; illegal opcodes skip the ALU entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc) state_nxt = acc_ill ? RESP : EXEC;
      EXEC: if (cnt_done) state_nxt = RESP;
      RESP: if (resp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: request ready only in IDLE, response valid only in RESP,
  // ALU opcode parked at 7 outside EXEC so the ALU holds its result
  always_comb begin
    bus.req0_ready  = (state == IDLE) && gnt0;
    bus.req1_ready  = (state == IDLE) && gnt1;
    bus.resp0_valid = (state == RESP) && !id_q;
    bus.resp1_valid = (state == RESP) && id_q;
    bus.alu_op      = (state == EXEC) ? op_q : OP_IDLE;
    dbg_state       = state;
  end

  // Result fields are shared by both response channels; only valid differs
  assign bus.resp0_r   = r_q;
  assign bus.resp0_lt  = lt_q;
  assign bus.resp0_err = err_q;
  assign bus.resp1_r   = r_q;
  assign bus.resp1_lt  = lt_q;
  assign bus.resp1_err = err_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;

  // Operand latch, latency counter, result capture and round-robin pointer.
  // Operands only reload for legal ops so the ALU inputs keep their last
  // values while the ALU is parked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_IDLE;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      r_q        <= '0;
      lt_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            id_q <= gnt1;
            op_q <= acc_op;
            cnt  <= '0;
            if (acc_ill) begin
              r_q   <= '0;
              lt_q  <= 1'b0;
              err_q <= 1'b1;
            end else begin
              a_q <= acc_a;
              b_q <= acc_b;
            end
          end
        end
        EXEC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt_done) begin
            err_q <= 1'b0;
            if (op_q == OP_SLT) begin
              r_q  <= '0;
              lt_q <= bus.alu_altb;
            end else begin
              r_q  <= bus.alu_r;
              lt_q <= 1'b0;
            end
          end
        end
        RESP: begin
          if (resp_hs) last_grant <= id_q;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating count of accepted requests per requester, illegal ops included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (acc) begin
      if (!gnt1 && (grant_cnt0 != 16'hFFFF)) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (gnt1  && (grant_cnt1 != 16'hFFFF)) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule
